// File: rtl/booth_pp_accumulator.sv
// booth_pp_accumulator
//
// Sequential reducer for the four partial-product rows of a signed 8x8
// radix-4 Booth multiplier whose rows use compressed sign extension. A row
// set is captured on an input valid/ready handshake. It is summed into a
// 16-bit accumulator over 4/ROWS_PER_CYCLE cycles. The 16-bit two's-complement
// product is then offered on an output valid/ready handshake.
//
// The sign information is already folded into the row bits. The product is
// therefore the plain modulo-2^16 sum of the zero-extended, column-aligned rows:
//   product = pp00 + pp01 + (pp02 << 2) + (pp03 << 4)   (mod 2^16)
//
// Parameters
//   ROWS_PER_CYCLE  rows added per accumulate cycle (1, 2 or 4)
//   OUT_REG         1: product comes from a dedicated register loaded when
//                      the sum completes; 0: product is the accumulator itself
//
// Ports
//   clk        in   1   clock, rising edge
//   rst        in   1   asynchronous reset, active-high
//   in_valid   in   1   row set on pp00..pp03 is valid
//   in_ready   out  1   block can accept a row set (IDLE only)
//   pp00       in   12  row 0, column offset 0
//   pp01       in   13  row 1, column offset 0 (bit0 = row-0 negate correction)
//   pp02       in   13  row 2, column offset 2
//   pp03       in   12  row 3, column offset 4
//   out_valid  out  1   product valid (DONE)
//   out_ready  in   1   downstream accepts product
//   product    out  16  signed product
//   busy       out  1   high while an operation is in flight (ACC or DONE)

module booth_pp_accumulator #(
    parameter int ROWS_PER_CYCLE = 1,
    parameter bit OUT_REG        = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [11:0]        pp00,
    input  logic [12:0]        pp01,
    input  logic [12:0]        pp02,
    input  logic [11:0]        pp03,
    output logic               out_valid,
    input  logic               out_ready,
    output logic signed [15:0] product,
    output logic               busy
);

    // Number of cycles that actually add rows.
    localparam int         ACC_CYCLES = 4 / ROWS_PER_CYCLE;
    localparam logic [2:0] LAST_ADD   = 3'(ACC_CYCLES - 1);
    // row_cnt value reached once every row is in the accumulator. With
    // OUT_REG=1 the FSM idles one cycle at this value to load the output
    // register.
    localparam logic [2:0] TERMINAL   = 3'(ACC_CYCLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [11:0] row0;
    logic [12:0] row1;
    logic [12:0] row2;
    logic [11:0] row3;
    logic [15:0] acc;
    logic [15:0] addend;
    logic [2:0]  row_cnt;
    logic [4:0]  row_idx;
    logic        acc_last;

    // Zero-extends one captured row and places it at its column offset.
    // Indices past row 3 contribute nothing.
    function automatic logic [15:0] row_term(
        input logic [4:0]  idx,
        input logic [11:0] r0,
        input logic [12:0] r1,
        input logic [12:0] r2,
        input logic [11:0] r3
    );
        logic [15:0] t;
        case (idx)
            5'd0:    t = {4'b0000, r0};
            5'd1:    t = {3'b000, r1};
            5'd2:    t = {1'b0, r2, 2'b00};
            5'd3:    t = {r3, 4'b0000};
            default: t = '0;
        endcase
        return t;
    endfunction

    // Sum of the rows scheduled for the current accumulate cycle: rows
    // row_cnt*RPC .. row_cnt*RPC+RPC-1, ascending.
    always_comb begin
        addend  = '0;
        row_idx = '0;
        for (int k = 0; k < ROWS_PER_CYCLE; k++) begin
            row_idx = 5'(row_cnt) * 5'(ROWS_PER_CYCLE) + 5'(k);
            addend  = addend + row_term(row_idx, row0, row1, row2, row3);
        end
    end

    // Leave ACC after the cycle that adds row 3. With an output register,
    // leave one cycle later, while the register loads.
    assign acc_last = OUT_REG ? (row_cnt == TERMINAL) : (row_cnt == LAST_ADD);

    // ---------------- FSM state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------- FSM next state ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = ACC;
            ACC:     if (acc_last) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- row capture and accumulation ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row0    <= '0;
            row1    <= '0;
            row2    <= '0;
            row3    <= '0;
            acc     <= '0;
            row_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        row0    <= pp00;
                        row1    <= pp01;
                        row2    <= pp02;
                        row3    <= pp03;
                        acc     <= '0;
                        row_cnt <= '0;
                    end
                end
                ACC: begin
                    if (row_cnt != TERMINAL) begin
                        acc     <= acc + addend;
                        row_cnt <= row_cnt + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------- output stage ----------------
    generate
        if (OUT_REG) begin : g_out_reg
            logic [15:0] prod_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    prod_q <= '0;
                end else if (state == ACC && row_cnt == TERMINAL) begin
                    prod_q <= acc;
                end
            end

            assign product = $signed(prod_q);
        end else begin : g_out_acc
            // The accumulator is frozen in DONE, so it can drive the port directly.
            assign product = $signed(acc);
        end
    endgenerate

    // in_ready is held low while reset is asserted. No handshake can then
    // appear to complete during reset.
    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_booth_pp_accumulator.sv
module tb_booth_pp_accumulator;

    typedef struct {
        logic [11:0] p0;
        logic [12:0] p1;
        logic [12:0] p2;
        logic [11:0] p3;
        logic [15:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] pp00;
    logic [12:0] pp01;
    logic [12:0] pp02;
    logic [11:0] pp03;
    logic        out_ready;

    // Six instances cover ROWS_PER_CYCLE x OUT_REG. cfg = 2*rpc_sel + out_reg.
    // cfg 1 (RPC=1, OUT_REG=1) is the default configuration.
    logic        iv_a   [6];
    logic        ir_a   [6];
    logic        ov_a   [6];
    logic        busy_a [6];
    logic [15:0] prod_a [6];

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 6; g++) begin : g_dut
        localparam int RPC = (g / 2 == 0) ? 1 : ((g / 2 == 1) ? 2 : 4);
        localparam bit ORG = (g % 2) == 1;
        booth_pp_accumulator #(
            .ROWS_PER_CYCLE(RPC),
            .OUT_REG(ORG)
        ) u_dut (
            .clk(clk),
            .rst(rst),
            .in_valid(iv_a[g]),
            .in_ready(ir_a[g]),
            .pp00(pp00),
            .pp01(pp01),
            .pp02(pp02),
            .pp03(pp03),
            .out_valid(ov_a[g]),
            .out_ready(out_ready),
            .product(prod_a[g]),
            .busy(busy_a[g])
        );
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer sum of the aligned rows, wrapped to 16 bits.
    function automatic logic [15:0] ref_prod(input vec_t v);
        int s;
        s = int'(v.p0) + int'(v.p1) + int'(v.p2) * 4 + int'(v.p3) * 16;
        return 16'(s);
    endfunction

    function automatic int exp_lat(input int cfg);
        int rpc;
        rpc = (cfg / 2 == 0) ? 1 : ((cfg / 2 == 1) ? 2 : 4);
        return 4 / rpc + (cfg % 2);
    endfunction

    task automatic drive_rows(input vec_t v);
        pp00 = v.p0;
        pp01 = v.p1;
        pp02 = v.p2;
        pp03 = v.p3;
    endtask

    task automatic scramble_rows();
        pp00 = 12'($urandom);
        pp01 = 13'($urandom);
        pp02 = 13'($urandom);
        pp03 = 12'($urandom);
    endtask

    // Entered and left on a falling edge. Runs one complete operation on
    // instance cfg. Returns the product and the count of rising edges from
    // the input handshake to the first out_valid.
    task automatic run_op(input int cfg, input vec_t v, output logic [15:0] prod, output int lat);
        int guard;
        drive_rows(v);
        iv_a[cfg] = 1'b1;
        guard = 0;
        while (!ir_a[cfg] && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("accept_ready", 32'(ir_a[cfg]), 32'd1);
        @(negedge clk);
        iv_a[cfg] = 1'b0;
        scramble_rows();
        lat = 0;
        while (!ov_a[cfg] && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        prod = prod_a[cfg];
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    vec_t        tbl [9];
    logic [15:0] prod;
    int          lat;
    vec_t        rv;
    vec_t        q[$];
    int          got;
    bit          saw_ov;

    initial begin
        tbl[0] = '{12'h001, 13'h0002, 13'h0001, 12'h001, 16'h0017};
        tbl[1] = '{12'hFFF, 13'h1FFF, 13'h1FFF, 12'hFFF, 16'hAFEA};
        tbl[2] = '{12'h000, 13'h0000, 13'h0000, 12'h000, 16'h0000};
        tbl[3] = '{12'h800, 13'h0000, 13'h0000, 12'h000, 16'h0800};
        tbl[4] = '{12'h000, 13'h1000, 13'h0000, 12'h000, 16'h1000};
        tbl[5] = '{12'h000, 13'h0000, 13'h1000, 12'h000, 16'h4000};
        tbl[6] = '{12'h000, 13'h0000, 13'h0000, 12'h800, 16'h8000};
        tbl[7] = '{12'h123, 13'h0456, 13'h0089, 12'h0AB, 16'h124D};
        tbl[8] = '{12'h000, 13'h0000, 13'h1FFF, 12'hFFF, 16'h7FEC};

        rst = 1'b1;
        out_ready = 1'b0;
        pp00 = '0;
        pp01 = '0;
        pp02 = '0;
        pp03 = '0;
        for (int i = 0; i < 6; i++) iv_a[i] = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        // Reset state of every configuration
        for (int c = 0; c < 6; c++) begin
            check($sformatf("reset_in_ready_cfg%0d", c), 32'(ir_a[c]), 32'd1);
            check($sformatf("reset_out_valid_cfg%0d", c), 32'(ov_a[c]), 32'd0);
            check($sformatf("reset_busy_cfg%0d", c), 32'(busy_a[c]), 32'd0);
            check($sformatf("reset_product_cfg%0d", c), 32'(prod_a[c]), 32'd0);
        end
        @(negedge clk);

        // Table vectors on the default configuration
        for (int i = 0; i < 9; i++) begin
            run_op(1, tbl[i], prod, lat);
            check($sformatf("tbl%0d_product", i), 32'(prod), 32'(tbl[i].exp));
            check($sformatf("tbl%0d_latency", i), 32'(lat), 32'(exp_lat(1)));
        end

        // Parameter sweep: offsets and wrap vectors on every configuration
        for (int c = 0; c < 6; c++) begin
            for (int i = 0; i < 2; i++) begin
                run_op(c, tbl[i], prod, lat);
                check($sformatf("sweep_cfg%0d_v%0d_product", c, i), 32'(prod), 32'(tbl[i].exp));
                check($sformatf("sweep_cfg%0d_v%0d_latency", c, i), 32'(lat), 32'(exp_lat(c)));
            end
        end

        // Reset in the middle of accumulation
        drive_rows(tbl[7]);
        iv_a[1] = 1'b1;
        @(negedge clk);
        iv_a[1] = 1'b0;
        @(negedge clk);
        check("midacc_busy_before_rst", 32'(busy_a[1]), 32'd1);
        rst = 1'b1;
        #1;
        check("midacc_rst_out_valid", 32'(ov_a[1]), 32'd0);
        check("midacc_rst_busy", 32'(busy_a[1]), 32'd0);
        check("midacc_rst_product", 32'(prod_a[1]), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midacc_post_in_ready", 32'(ir_a[1]), 32'd1);
        check("midacc_post_product", 32'(prod_a[1]), 32'd0);
        saw_ov = 1'b0;
        out_ready = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (ov_a[1]) saw_ov = 1'b1;
        end
        out_ready = 1'b0;
        check("midacc_no_stale_output", 32'(saw_ov), 32'd0);

        // Backpressure in DONE, with in_valid asserted throughout the stall
        drive_rows(tbl[0]);
        iv_a[1] = 1'b1;
        @(negedge clk);
        iv_a[1] = 1'b0;
        lat = 0;
        while (!ov_a[1] && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check("stall_reach_done", 32'(ov_a[1]), 32'd1);
        drive_rows(tbl[1]);
        iv_a[1] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("stall%0d_out_valid", k), 32'(ov_a[1]), 32'd1);
            check($sformatf("stall%0d_product", k), 32'(prod_a[1]), 32'h0017);
            check($sformatf("stall%0d_in_ready", k), 32'(ir_a[1]), 32'd0);
        end
        // in_valid and out_ready together in DONE: only the output handshake completes
        out_ready = 1'b1;
        @(negedge clk);
        iv_a[1] = 1'b0;
        out_ready = 1'b0;
        check("release_out_valid", 32'(ov_a[1]), 32'd0);
        check("release_in_ready", 32'(ir_a[1]), 32'd1);
        @(negedge clk);
        check("release_no_bypass_busy", 32'(busy_a[1]), 32'd0);

        // Random streaming with random input gaps and output backpressure
        got = 0;
        fork
            begin : producer
                int guard;
                for (int n = 0; n < 100; n++) begin
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                    rv.p0 = 12'($urandom);
                    rv.p1 = 13'($urandom);
                    rv.p2 = 13'($urandom);
                    rv.p3 = 12'($urandom);
                    rv.exp = ref_prod(rv);
                    drive_rows(rv);
                    iv_a[1] = 1'b1;
                    guard = 0;
                    while (!ir_a[1] && guard < 200) begin
                        @(negedge clk);
                        guard++;
                    end
                    if (!ir_a[1]) begin
                        check("stream_accept", 32'(ir_a[1]), 32'd1);
                        iv_a[1] = 1'b0;
                        break;
                    end
                    q.push_back(rv);
                    @(negedge clk);
                    iv_a[1] = 1'b0;
                    scramble_rows();
                end
            end
            begin : consumer
                int          cyc;
                bit          r;
                bit          prev_stall;
                logic [15:0] prev_prod;
                vec_t        e;
                cyc = 0;
                prev_stall = 1'b0;
                prev_prod = '0;
                while (got < 100 && cyc < 6000) begin
                    @(negedge clk);
                    cyc++;
                    r = 1'($urandom_range(0, 1));
                    out_ready = r;
                    if (prev_stall) begin
                        check("stream_hold_valid", 32'(ov_a[1]), 32'd1);
                        check("stream_hold_product", 32'(prod_a[1]), 32'(prev_prod));
                    end
                    if (ov_a[1]) begin
                        if (r) begin
                            if (q.size() == 0) begin
                                check("stream_unexpected_output", 32'd1, 32'd0);
                            end else begin
                                e = q.pop_front();
                                check($sformatf("stream%0d_product", got), 32'(prod_a[1]), 32'(e.exp));
                            end
                            got++;
                        end
                        prev_stall = !r;
                        prev_prod = prod_a[1];
                    end else begin
                        prev_stall = 1'b0;
                    end
                end
                @(negedge clk);
                out_ready = 1'b0;
            end
        join
        check("stream_delivered", 32'(got), 32'd100);
        check("stream_queue_empty", 32'(q.size()), 32'd0);
        saw_ov = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (ov_a[1]) saw_ov = 1'b1;
        end
        check("stream_no_duplicate", 32'(saw_ov), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
